// File: rtl/prog_pla_pipe.sv
// Field-programmable PLA with loadable AND/OR planes and a 2-stage valid/ready evaluation pipeline.
// Optional build macro PLA_POLARITY_EN adds a per-output polarity register (cfg_sel=2).
module prog_pla_pipe #(
   parameter  int N_IN   = 4,
   parameter  int N_TERM = 16,
   parameter  int N_OUT  = 4,
   localparam int AW     = $clog2(N_TERM),
   localparam int DW     = (2 * N_IN > N_TERM) ? 2 * N_IN : N_TERM
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [AW-1:0]     cfg_addr,
   input  logic [DW-1:0]     cfg_wdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_IN-1:0]   in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_OUT-1:0]  out_data
);

   logic [2*N_IN-1:0] and_plane [N_TERM];
   logic [N_TERM-1:0] or_plane  [N_OUT];
   logic [N_OUT-1:0]  pol;

   logic              vld_p1, vld_p2;
   logic [N_TERM-1:0] term_p1;
   logic [N_OUT-1:0]  res_p2;

   logic              s1_adv, s2_adv;
   logic [N_TERM-1:0] term_now;
   logic [N_OUT-1:0]  sum_now;

   assign s2_adv    = !vld_p2 || out_ready;
   assign s1_adv    = !vld_p1 || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = vld_p2;
   assign out_data  = res_p2;

   // Out-of-range addresses match no index in the loops, so such writes are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < N_TERM; j++) and_plane[j] <= '0;
         for (int k = 0; k < N_OUT; k++) or_plane[k] <= '0;
      end else if (cfg_we) begin
         case (cfg_sel)
            2'd0: begin
               for (int j = 0; j < N_TERM; j++)
                  if (int'(cfg_addr) == j) and_plane[j] <= cfg_wdata[2*N_IN-1:0];
            end
            2'd1: begin
               for (int k = 0; k < N_OUT; k++)
                  if (int'(cfg_addr) == k) or_plane[k] <= cfg_wdata[N_TERM-1:0];
            end
            default: ;
         endcase
      end
   end

`ifdef PLA_POLARITY_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         pol <= '0;
      else if (cfg_we && cfg_sel == 2'd2)
         pol <= cfg_wdata[N_OUT-1:0];
   end
`else
   assign pol = '0;
`endif

   // Both mask bits set for one input makes the term unsatisfiable; an empty mask is constant 1.
   always_comb begin
      term_now = '1;
      for (int j = 0; j < N_TERM; j++) begin
         for (int i = 0; i < N_IN; i++) begin
            if (and_plane[j][2*i] && !in_data[i])
               term_now[j] = 1'b0;
            if (and_plane[j][2*i+1] && in_data[i])
               term_now[j] = 1'b0;
         end
      end
   end

   always_comb begin
      sum_now = '0;
      for (int k = 0; k < N_OUT; k++)
         sum_now[k] = (|(or_plane[k] & term_p1)) ^ pol[k];
   end

   // Stage 1: AND plane -> term vector; stage 2: OR plane (+ polarity) -> result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         vld_p2  <= 1'b0;
         term_p1 <= '0;
         res_p2  <= '0;
      end else begin
         if (s1_adv) begin
            vld_p1 <= in_valid;
            if (in_valid)
               term_p1 <= term_now;
         end
         if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1)
               res_p2 <= sum_now;
         end
      end
   end

endmodule
